weight_stream_reader: RTL and testbench
=======================================

Name: weight_stream_reader

Overview:
- Read-side initiator for the single-port weight/state BRAM block. It drives the RAM read port (`ce0`/`addr0`) and absorbs the RAM's fixed 2-cycle read latency.
- It delivers a burst of words as a valid/ready stream to the LSTM gate MAC datapath.
- A small internal FIFO holds words already in flight from the RAM, so downstream backpressure never drops or duplicates a word.

Parameters:
- `RAM_WIDTH`, 16, data word width; must match the RAM.
- `RAM_ADDR`, 9, RAM address width.
- `RAM_DEPTH`, 400, number of RAM entries; addresses wrap at `RAM_DEPTH-1`.
- `LEN_W`, 10, width of the burst-length field.
- `READ_LAT`, 2, RAM read latency in cycles (from `ce0` to data valid on `rd_data`).
- `FIFO_DEPTH`, 4, output buffer entries; must be at least `READ_LAT+1`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a burst; ignored while `busy`=1.
- `base_addr`  in  `RAM_ADDR`  first address of the burst; sampled on `start`.
- `burst_len`  in  `LEN_W`  number of words; sampled on `start`.
- `ce0`  out  1  RAM read enable.
- `addr0`  out  `RAM_ADDR`  RAM read address.
- `rd_data`  in  `RAM_WIDTH`  RAM read data; valid `READ_LAT` cycles after the `ce0` cycle.
- `dout`  out  `RAM_WIDTH`  stream data.
- `dout_valid`  out  1  stream valid.
- `dout_ready`  in  1  stream ready from the consumer.
- `dout_last`  out  1  marks the final word of a burst; qualified by `dout_valid`.
- `busy`  out  1  high from accepted `start` until the final word is accepted.
- `done`  out  1  one-cycle pulse, the cycle after the final handshake.

Behaviour:
- Reset: all of the following are 0:
  - outputs `ce0`, `addr0`, `dout`, `dout_valid`, `dout_last`, `busy`, `done`;
  - the FIFO, the in-flight shift register and the counters.
  - Reset takes effect immediately at any time, including mid-burst; the burst is abandoned and no `done` pulse is produced.
- FSM states: `IDLE`, `ISSUE`, `DRAIN`.
  - `IDLE`, `start`=1, `burst_len`≠0: latch `base_addr` and `burst_len`, go to `ISSUE`, set `busy`=1.
  - `IDLE`, `start`=1, `burst_len`=0: no reads issued; `done`=1 on the next cycle; stay in `IDLE`.
  - `ISSUE`: assert `ce0`=1 with `addr0`=current address in any cycle where fifo_count + inflight_count < `FIFO_DEPTH` (credit check). Each issue decrements the remaining-issue counter.
  - `ISSUE` → `DRAIN` after the last issue.
  - `DRAIN` → `IDLE` when inflight_count = 0, the FIFO is empty, and the final word's handshake has completed.
  - In `IDLE`, `done`=1 for one cycle after that transition and `busy`=0.
- Address generation:
  - The next address is current + 1.
  - If current = `RAM_DEPTH-1`, the next address is 0. No address outside 0..`RAM_DEPTH-1` is ever driven.
- `ce0`=0 in every non-issue cycle. `addr0` holds its last value when `ce0`=0.
- In-flight tracking:
  - A `READ_LAT`-deep valid shift register records each issue.
  - When its tail bit is set, `rd_data` is written into the FIFO in that cycle.
  - A tag bit travels with the last issue and becomes the FIFO's last flag.
- FIFO: registered; `dout`/`dout_valid`/`dout_last` come directly from the head entry.
  - Pop on `dout_valid` & `dout_ready`.
  - Simultaneous push and pop in one cycle is legal; count is unchanged.
  - The credit check guarantees the FIFO never overflows. Verification asserts fifo_count ≤ `FIFO_DEPTH` at all times.
- Throughput: with `dout_ready` held at 1, one word per cycle after an initial latency of `READ_LAT`+1 cycles from `start` to the first `dout_valid`.
  - Burst of N words completes (final handshake) at cycle N+`READ_LAT` after `start`.
  - `done` pulses at cycle N+`READ_LAT`+1.
- Stream stability: while `dout_valid`=1 and `dout_ready`=0, `dout` and `dout_last` are held stable.
- `start` while `busy`=1 is ignored; no state change.

Optional Feature:
- Macro: `WSR_STRIDE_EN`.
- Defined:
  - Adds input port `stride` (width `RAM_ADDR`), sampled on `start`.
  - The next address is (current + stride) mod `RAM_DEPTH`, computed with one conditional subtraction. `stride` must be < `RAM_DEPTH`.
  - This allows column-wise walks of row-major weight matrices.
- Undefined: no `stride` port; stride is fixed at 1.

Decomposition:
- Shared package `lstm_mem_pkg`: `RAM_WIDTH`, `RAM_ADDR`, `RAM_DEPTH`, `READ_LAT` constants, and the FSM state enum type.
- Sub-module `stream_sync_fifo`: parameterised by width (`RAM_WIDTH`+1 to carry the last flag) and depth. It provides push, pop, count, full and empty.
- The FSM, address generator and in-flight register remain in the top module.

Test Plan:
- Basic burst: `base_addr`=10, `burst_len`=5, `dout_ready`=1; RAM preloaded mem[i]=i → `dout` sequence 10,11,12,13,14; `dout_last` on 14; `done` at cycle 8 after `start`.
- Wrap-around: `base_addr`=398, `burst_len`=4 → `addr0` sequence 398,399,0,1; data 398,399,0,1.
- Backpressure: `burst_len`=8, `dout_ready` toggling 1,0,0,1,… → all 8 words delivered in order with no duplicates; `dout` stable while stalled; fifo_count never exceeds 4; `ce0` deasserted while credit is exhausted.
- Zero length and ignored start: `burst_len`=0 → no `ce0`, `done` next cycle. A second `start` mid-burst → ignored; the original burst completes unchanged.
- Reset mid-burst: assert `reset` at word 3 of 6 → all outputs 0 immediately, no `done`. A new burst after reset starts cleanly from its own `base_addr`.
- `WSR_STRIDE_EN`: `base_addr`=5, `stride`=100, `burst_len`=5 → `addr0` sequence 5,105,205,305,5 (405 wraps mod 400 to 5).

Source files
------------

// File: rtl/lstm_mem_pkg.sv
// Shared constants and types for the LSTM weight/state memory read path.
package lstm_mem_pkg;

    localparam int MEM_RAM_WIDTH = 16;
    localparam int MEM_RAM_ADDR  = 9;
    localparam int MEM_RAM_DEPTH = 400;
    localparam int MEM_READ_LAT  = 2;

    // Burst reader control states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10
    } wsr_state_e;

endpackage

// File: rtl/stream_sync_fifo.sv
// Small synchronous FIFO for the read stream. The head entry drives the
// consumer directly. A push and a pop in the same cycle leave the count
// unchanged. A push into a full FIFO without a matching pop is dropped.
module stream_sync_fifo
    import lstm_mem_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == {CNT_W{1'b0}});
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
                wr_ptr_d = {PTR_W{1'b0}};
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            if (rd_ptr_q == PTR_W'(DEPTH - 1)) begin
                rd_ptr_d = {PTR_W{1'b0}};
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/weight_stream_reader.sv
// Burst read initiator for the weight/state BRAM. It issues reads against a
// credit budget so every word in flight has a FIFO slot waiting for it. The
// words are then streamed out with valid/ready.
// Optional feature: define WSR_STRIDE_EN to add a 'stride' port. The address
// then advances by stride modulo RAM_DEPTH instead of by one.
module weight_stream_reader
    import lstm_mem_pkg::*;
#(
    parameter int RAM_WIDTH  = MEM_RAM_WIDTH,
    parameter int RAM_ADDR   = MEM_RAM_ADDR,
    parameter int RAM_DEPTH  = MEM_RAM_DEPTH,
    parameter int LEN_W      = 10,
    parameter int READ_LAT   = MEM_READ_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [RAM_ADDR-1:0]  base_addr,
    input  logic [LEN_W-1:0]     burst_len,
`ifdef WSR_STRIDE_EN
    input  logic [RAM_ADDR-1:0]  stride,
`endif
    output logic                 ce0,
    output logic [RAM_ADDR-1:0]  addr0,
    input  logic [RAM_WIDTH-1:0] rd_data,
    output logic [RAM_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CW    = $clog2(FIFO_DEPTH + READ_LAT + 2) + 1;

    wsr_state_e            state_q, state_d;
    logic                  ce0_q, ce0_d;
    logic [RAM_ADDR-1:0]   addr0_q, addr0_d;
    logic [RAM_ADDR-1:0]   next_addr_q, next_addr_d;
    logic [LEN_W-1:0]      issue_left_q, issue_left_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [READ_LAT-1:0]   sr_valid_q, sr_valid_d;
    logic [READ_LAT-1:0]   sr_last_q, sr_last_d;
    logic [RAM_ADDR-1:0]   step_s;
    logic [RAM_ADDR-1:0]   start_step_s;

`ifdef WSR_STRIDE_EN
    logic [RAM_ADDR-1:0]   stride_q, stride_d;
    assign step_s       = stride_q;
    assign start_step_s = stride;
`else
    assign step_s       = {{(RAM_ADDR-1){1'b0}}, 1'b1};
    assign start_step_s = {{(RAM_ADDR-1){1'b0}}, 1'b1};
`endif

    logic [RAM_WIDTH:0]    fifo_head_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  pop_s;
    logic                  head_last_s;
    logic [CW-1:0]         credit_sum_s;
    logic                  credit_ok_s;

    // Address step with wrap at RAM_DEPTH: one conditional subtraction.
    // It relies on both cur and step being below RAM_DEPTH.
    function automatic logic [RAM_ADDR-1:0] addr_advance(
        input logic [RAM_ADDR-1:0] cur,
        input logic [RAM_ADDR-1:0] step
    );
        logic [RAM_ADDR:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (sum >= (RAM_ADDR+1)'(RAM_DEPTH)) begin
            sum = sum - (RAM_ADDR+1)'(RAM_DEPTH);
        end else begin
            sum = sum;
        end
        return RAM_ADDR'(sum);
    endfunction

    assign dout_valid  = ~fifo_empty_s;
    assign dout        = fifo_head_s[RAM_WIDTH-1:0];
    assign head_last_s = fifo_head_s[RAM_WIDTH];
    assign dout_last   = head_last_s & dout_valid;
    assign pop_s       = dout_valid & dout_ready;
    assign ce0         = ce0_q;
    assign addr0       = addr0_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Words committed for the next cycle: held in the FIFO plus issued but
    // not yet landed, minus any word leaving this cycle. A read for next
    // cycle is allowed only if that word still has a free FIFO slot.
    always_comb begin
        credit_sum_s = CW'(fifo_count_s) + CW'(ce0_q);
        for (int i = 0; i < READ_LAT; i++) begin
            credit_sum_s = credit_sum_s + CW'(sr_valid_q[i]);
        end
        if (pop_s) begin
            credit_sum_s = credit_sum_s - CW'(1);
        end else begin
            credit_sum_s = credit_sum_s;
        end
        credit_ok_s = ~fifo_full_s & (credit_sum_s < CW'(FIFO_DEPTH));
    end

    // In-flight pipeline: one stage per cycle of RAM read latency; the tail
    // stage marks the cycle in which rd_data is valid
    always_comb begin
        sr_valid_d    = sr_valid_q;
        sr_last_d     = sr_last_q;
        sr_valid_d[0] = ce0_q;
        sr_last_d[0]  = ce0_q & last_q;
        for (int i = 1; i < READ_LAT; i++) begin
            sr_valid_d[i] = sr_valid_q[i-1];
            sr_last_d[i]  = sr_last_q[i-1];
        end
    end

    // Control FSM: ce0 and addr0 are decided one cycle ahead and registered
    always_comb begin
        state_d      = state_q;
        ce0_d        = 1'b0;
        addr0_d      = addr0_q;
        next_addr_d  = next_addr_q;
        issue_left_d = issue_left_q;
        last_d       = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef WSR_STRIDE_EN
        stride_d     = stride_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (burst_len != {LEN_W{1'b0}}) begin
                        state_d      = ISSUE;
                        busy_d       = 1'b1;
                        ce0_d        = 1'b1;
                        addr0_d      = base_addr;
                        next_addr_d  = addr_advance(base_addr, start_step_s);
                        issue_left_d = burst_len - LEN_W'(1);
                        last_d       = (burst_len == LEN_W'(1));
`ifdef WSR_STRIDE_EN
                        stride_d     = stride;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (issue_left_q == {LEN_W{1'b0}}) begin
                    // the final read is on the RAM port this cycle
                    state_d = DRAIN;
                end else if (credit_ok_s) begin
                    ce0_d        = 1'b1;
                    addr0_d      = next_addr_q;
                    next_addr_d  = addr_advance(next_addr_q, step_s);
                    issue_left_d = issue_left_q - LEN_W'(1);
                    last_d       = (issue_left_q == LEN_W'(1));
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (pop_s && head_last_s &&
                    (fifo_count_s == CNT_W'(1)) &&
                    (sr_valid_q == {READ_LAT{1'b0}})) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control, address and in-flight registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ce0_q        <= 1'b0;
            addr0_q      <= {RAM_ADDR{1'b0}};
            next_addr_q  <= {RAM_ADDR{1'b0}};
            issue_left_q <= {LEN_W{1'b0}};
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sr_valid_q   <= {READ_LAT{1'b0}};
            sr_last_q    <= {READ_LAT{1'b0}};
`ifdef WSR_STRIDE_EN
            stride_q     <= {RAM_ADDR{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            ce0_q        <= ce0_d;
            addr0_q      <= addr0_d;
            next_addr_q  <= next_addr_d;
            issue_left_q <= issue_left_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sr_valid_q   <= sr_valid_d;
            sr_last_q    <= sr_last_d;
`ifdef WSR_STRIDE_EN
            stride_q     <= stride_d;
`endif
        end
    end

    stream_sync_fifo #(
        .WIDTH (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (sr_valid_q[READ_LAT-1]),
        .push_data ({sr_last_q[READ_LAT-1], rd_data}),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_weight_stream_reader.sv
// Directed bench for weight_stream_reader with a 2-cycle-latency RAM model.
module tb_weight_stream_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  burst_len;
    logic [8:0]  stride;
    logic        ce0;
    logic [8:0]  addr0;
    logic [15:0] rd_data;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      name;
        int         base;
        int         len;
        int         step;
        logic [15:0] rmask;
        int         exp_done;
        bit         exp_throttle;
        int         restart_at;
    } vec_t;

    vec_t vecs[$];

    weight_stream_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .burst_len  (burst_len),
`ifdef WSR_STRIDE_EN
        .stride     (stride),
`endif
        .ce0        (ce0),
        .addr0      (addr0),
        .rd_data    (rd_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: mem[i] = i, data valid two cycles after the ce0 cycle
    logic [15:0] mem [0:399];
    logic [15:0] ram_p1;
    always @(posedge clk) begin
        if (ce0) ram_p1 <= mem[addr0];
        rd_data <= ram_p1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string what, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", what, actual, expected);
        end
    endtask

    task automatic add_vec(input string name, input int base, input int len, input int step,
                           input logic [15:0] rmask, input int exp_done, input bit thr,
                           input int restart_at);
        vec_t v;
        v.name = name; v.base = base; v.len = len; v.step = step; v.rmask = rmask;
        v.exp_done = exp_done; v.exp_throttle = thr; v.restart_at = restart_at;
        vecs.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ce0"}, int'(ce0), 0);
        check({tag, "_addr0"}, int'(addr0), 0);
        check({tag, "_dout"}, int'(dout), 0);
        check({tag, "_dout_valid"}, int'(dout_valid), 0);
        check({tag, "_dout_last"}, int'(dout_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Run one burst, checking addresses, data order, last flag, stalls,
    // outstanding-word bound and done timing (cycle 0 = cycle after start edge)
    task automatic run_burst(input vec_t v);
        int issued, accepted, exp_addr_i, exp_data_i, idle_gaps, cyc;
        bit stalled, got_done;
        logic [15:0] held_d;
        logic held_l;
        issued = 0; accepted = 0; idle_gaps = 0;
        exp_addr_i = v.base; exp_data_i = v.base;
        stalled = 1'b0; got_done = 1'b0; held_d = 16'h0000; held_l = 1'b0;
        @(negedge clk);
        start = 1'b1;
        base_addr = 9'(v.base);
        burst_len = 10'(v.len);
        stride = 9'(v.step);
        @(negedge clk);
        start = 1'b0;
        check({v.name, "_busy_start"}, int'(busy), 1);
        for (cyc = 0; cyc < 300 && !got_done; cyc++) begin
            if (cyc == v.restart_at) begin
                start = 1'b1; base_addr = 9'd300; burst_len = 10'd3;
            end else begin
                start = 1'b0;
            end
            if (ce0) begin
                check({v.name, "_addr0"}, int'(addr0), exp_addr_i);
                exp_addr_i = (exp_addr_i + v.step) % 400;
                issued++;
            end else if (issued > 0 && issued < v.len) begin
                idle_gaps++;
            end
            check({v.name, "_outstanding_le4"}, int'((issued - accepted) <= 4), 1);
            if (done) begin
                got_done = 1'b1;
                if (v.exp_done >= 0) check({v.name, "_done_cycle"}, cyc, v.exp_done);
                check({v.name, "_accepted"}, accepted, v.len);
            end else begin
                if (stalled) begin
                    check({v.name, "_stall_valid"}, int'(dout_valid), 1);
                    check({v.name, "_stall_dout"}, int'(dout), int'(held_d));
                    check({v.name, "_stall_last"}, int'(dout_last), int'(held_l));
                end
                dout_ready = v.rmask[cyc % 16];
                if (dout_valid) begin
                    if (dout_ready) begin
                        check({v.name, "_dout"}, int'(dout), exp_data_i);
                        check({v.name, "_last"}, int'(dout_last), int'(accepted == v.len - 1));
                        exp_data_i = (exp_data_i + v.step) % 400;
                        accepted++;
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        held_d = dout;
                        held_l = dout_last;
                    end
                end else begin
                    stalled = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        dout_ready = 1'b1;
        check({v.name, "_got_done"}, int'(got_done), 1);
        check({v.name, "_issued"}, issued, v.len);
        check({v.name, "_busy_end"}, int'(busy), 0);
        if (v.exp_throttle) check({v.name, "_ce0_throttled"}, int'(idle_gaps > 0), 1);
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 400; i++) mem[i] = 16'(i);
        ram_p1 = 16'h0000;
        reset = 1'b1; start = 1'b0; base_addr = 9'd0; burst_len = 10'd0;
        stride = 9'd1; dout_ready = 1'b1;

        //               name         base len step rmask     done thr restart
        add_vec("basic",     10,  5, 1, 16'hFFFF,  8, 1'b0, -1);
        add_vec("wrap",     398,  4, 1, 16'hFFFF,  7, 1'b0, -1);
        add_vec("bp_toggle",  0,  8, 1, 16'h9999, -1, 1'b1, -1);
        add_vec("single",   200,  1, 1, 16'hFFFF,  4, 1'b0, -1);
        add_vec("bp_long",  390, 12, 1, 16'h8001, -1, 1'b1, -1);
        add_vec("edge399",  399,  2, 1, 16'hFFFF,  5, 1'b0, -1);
        add_vec("restart",   50,  6, 1, 16'hFFFF,  9, 1'b0,  2);
`ifdef WSR_STRIDE_EN
        add_vec("stride",     5,  5, 100, 16'hFFFF, 8, 1'b0, -1);
`endif

        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // zero-length burst
        start = 1'b1; base_addr = 9'd7; burst_len = 10'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", int'(done), 1);
        check("zero_ce0", int'(ce0), 0);
        check("zero_busy", int'(busy), 0);
        @(negedge clk);
        check("zero_done_pulse", int'(done), 0);
        check("zero_ce0_after", int'(ce0), 0);

        foreach (vecs[k]) run_burst(vecs[k]);

        // reset in the middle of a 6-word burst, after 3 words taken
        @(negedge clk);
        start = 1'b1; base_addr = 9'd100; burst_len = 10'd6; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 40 && acc < 3; c++) begin
            if (dout_valid) begin
                check("midrst_dout", int'(dout), 100 + acc);
                acc++;
            end
            @(negedge clk);
        end
        check("midrst_words_before", acc, 3);
        check("midrst_valid_before", int'(dout_valid), 1);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("midrst_no_done", int'(done), 0);
            check("midrst_no_ce0", int'(ce0), 0);
        end
        begin
            vec_t v;
            v.name = "after_rst"; v.base = 20; v.len = 3; v.step = 1; v.rmask = 16'hFFFF;
            v.exp_done = 6; v.exp_throttle = 1'b0; v.restart_at = -1;
            run_burst(v);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
